// File: rtl/car_warning_pkg.sv
// Shared state encoding and cause-bit positions for the car warning controller.
package car_warning_pkg;

  typedef enum logic [1:0] {
    OFF     = 2'b00,
    MONITOR = 2'b01,
    CHIME   = 2'b10,
    HOLD    = 2'b11
  } state_t;

  localparam int DOOR = 1;
  localparam int BELT = 0;

endpackage

// File: rtl/car_warning_ctrl_input_debounce.sv
// Two-flop synchroniser plus stability counter for one raw input.
// Latency DEB_CYC+2 cycles from raw change to deb; no backpressure.
module input_debounce #(
  parameter int DEB_CYC = 4,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb
);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      deb <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // Any return to the current debounced value restarts the stability count.
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYC - 1)) begin
        deb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/car_warning_ctrl.sv
// Debounced fault detector driving a bounded, acknowledgeable chime/lamp sequence.
// Outputs registered, one cycle behind the state; no backpressure.
module car_warning_ctrl
  import car_warning_pkg::*;
#(
  parameter int DEB_CYC   = 4,
  parameter int BEEP_ON   = 8,
  parameter int BEEP_OFF  = 8,
  parameter int MAX_BEEPS = 6,
  parameter int CNT_W     = 8
) (
  input  logic       Clk,
  input  logic       nRst,
  input  logic       DoorClose,
  input  logic       Ignition,
  input  logic       SeatBelt,
  input  logic       Ack,
  output logic       Alarm,
  output logic       WarnLamp,
  output logic [1:0] State
);

  localparam int BW = $clog2(MAX_BEEPS + 1);

  logic             door_d;
  logic             ign_d;
  logic             belt_d;
  logic [1:0]       cause;
  logic             fault;
  state_t           st;
  logic [1:0]       cause_q;
  logic [CNT_W-1:0] ph;
  logic             beep_on;
  logic [BW-1:0]    beeps;

  input_debounce #(.DEB_CYC(DEB_CYC), .CNT_W(CNT_W)) u_deb_door (
    .clk(Clk), .rst_n(nRst), .raw(DoorClose), .deb(door_d)
  );
  input_debounce #(.DEB_CYC(DEB_CYC), .CNT_W(CNT_W)) u_deb_ign (
    .clk(Clk), .rst_n(nRst), .raw(Ignition), .deb(ign_d)
  );
  input_debounce #(.DEB_CYC(DEB_CYC), .CNT_W(CNT_W)) u_deb_belt (
    .clk(Clk), .rst_n(nRst), .raw(SeatBelt), .deb(belt_d)
  );

  always_comb begin
    cause       = 2'b00;
    cause[DOOR] = ~door_d;
    cause[BELT] = ~belt_d;
    fault       = ign_d & (|cause);
  end

  assign State = st;

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      st       <= OFF;
      cause_q  <= 2'b00;
      ph       <= '0;
      beep_on  <= 1'b0;
      beeps    <= '0;
      Alarm    <= 1'b0;
      WarnLamp <= 1'b0;
    end else begin
      Alarm    <= (st == CHIME) && beep_on;
      WarnLamp <= (st == CHIME) || (st == HOLD);
      case (st)
        OFF: begin
          if (ign_d) st <= MONITOR;
        end
        MONITOR: begin
          if (!ign_d) begin
            st <= OFF;
          end else if (fault) begin
            st      <= CHIME;
            cause_q <= cause;
            ph      <= '0;
            beep_on <= 1'b1;
            beeps   <= '0;
          end
        end
        CHIME: begin
          if (!ign_d) begin
            st <= OFF;
          end else if (!fault) begin
            st <= MONITOR;
          end else if (Ack) begin
            st <= HOLD;
          end else if (beep_on) begin
            if (ph == CNT_W'(BEEP_ON - 1)) begin
              beep_on <= 1'b0;
              ph      <= '0;
            end else begin
              ph <= ph + 1'b1;
            end
          end else if (ph == CNT_W'(BEEP_OFF - 1)) begin
            // Leave on the same edge the last beep completes so no extra ON cycle leaks out.
            beep_on <= 1'b1;
            ph      <= '0;
            beeps   <= beeps + 1'b1;
            if (beeps == BW'(MAX_BEEPS - 1)) st <= HOLD;
          end else begin
            ph <= ph + 1'b1;
          end
        end
        HOLD: begin
          if (!ign_d) begin
            st <= OFF;
          end else if (!fault) begin
            st <= MONITOR;
          end else if (|(cause & ~cause_q)) begin
            st      <= CHIME;
            cause_q <= cause;
            ph      <= '0;
            beep_on <= 1'b1;
            beeps   <= '0;
          end
        end
        default: st <= OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_car_warning_ctrl.sv
// Scoreboard bench: per-cycle {State,Alarm,WarnLamp} expectations queued at stimulus time.
module tb_car_warning_ctrl;
  import car_warning_pkg::*;

  logic       Clk = 1'b0;
  logic       nRst = 1'b0;
  logic       DoorClose = 1'b0;
  logic       Ignition = 1'b0;
  logic       SeatBelt = 1'b0;
  logic       Ack = 1'b0;
  logic       Alarm;
  logic       WarnLamp;
  logic [1:0] State;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  always #5 Clk = ~Clk;

  car_warning_ctrl dut (
    .Clk(Clk), .nRst(nRst), .DoorClose(DoorClose), .Ignition(Ignition),
    .SeatBelt(SeatBelt), .Ack(Ack), .Alarm(Alarm), .WarnLamp(WarnLamp), .State(State)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic void push(input logic [1:0] s, input logic a, input logic l);
    exp_q.push_back({s, a, l});
  endfunction

  function automatic void push_n(input int n, input logic [1:0] s, input logic a, input logic l);
    for (int i = 0; i < n; i++) push(s, a, l);
  endfunction

  // Full chime episode: alarm k cycles after the first beep cycle, HOLD on the last one.
  function automatic void push_episode();
    for (int k = 0; k < 96; k++) push((k == 95) ? HOLD : CHIME, (k % 16) < 8, 1'b1);
  endfunction

  task automatic run(input string tag, input int n);
    logic [3:0] e;
    for (int i = 0; i < n; i++) begin
      tick();
      if (exp_q.size() == 0) begin
        chk({tag, "_underflow"}, 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk(tag, {State, Alarm, WarnLamp}, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    #2;
    chk("rst_state", State, OFF);
    chk("rst_alarm", Alarm, 1'b0);
    chk("rst_lamp", WarnLamp, 1'b0);
    tick(); tick();
    nRst = 1'b1;
    push_n(3, OFF, 0, 0); run("idle", 3);

    // 1: door closed, belt open -> six beeps then HOLD
    Ignition = 1'b1; DoorClose = 1'b1; SeatBelt = 1'b0;
    push_n(6, OFF, 0, 0); push(MONITOR, 0, 0); push(CHIME, 0, 0);
    push_episode(); push_n(6, HOLD, 0, 1);
    run("t1_episode", 110);

    // 2: back to MONITOR, re-fault, Ack mid-beep, then belt fastened
    SeatBelt = 1'b1;
    push_n(6, HOLD, 0, 1); push(MONITOR, 0, 1); push(MONITOR, 0, 0);
    run("t2_mon", 8);
    SeatBelt = 1'b0;
    push_n(6, MONITOR, 0, 0); push(CHIME, 0, 0); push_n(4, CHIME, 1, 1);
    run("t2_chime", 11);
    Ack = 1'b1; push(HOLD, 1, 1); run("t2_ack", 1); Ack = 1'b0;
    push_n(3, HOLD, 0, 1); run("t2_hold", 3);
    SeatBelt = 1'b1;
    push_n(6, HOLD, 0, 1); push(MONITOR, 0, 1); push(MONITOR, 0, 0);
    run("t2_belt", 8);

    // 3: HOLD on belt cause, door opens -> full re-armed episode; door closing does not re-arm
    SeatBelt = 1'b0;
    push_n(6, MONITOR, 0, 0); push(CHIME, 0, 0); push_n(2, CHIME, 1, 1);
    run("t3_chime", 9);
    Ack = 1'b1; push(HOLD, 1, 1); run("t3_ack", 1); Ack = 1'b0;
    push_n(2, HOLD, 0, 1); run("t3_hold", 2);
    DoorClose = 1'b0;
    push_n(6, HOLD, 0, 1); push(CHIME, 0, 1); push_episode(); push_n(4, HOLD, 0, 1);
    run("t3_rearm", 107);
    DoorClose = 1'b1;
    push_n(12, HOLD, 0, 1); run("t3_noarm", 12);

    // 4: 3-cycle glitch ignored, Ack outside CHIME ignored, 4+ cycle change accepted
    SeatBelt = 1'b1;
    push_n(6, HOLD, 0, 1); push(MONITOR, 0, 1); push(MONITOR, 0, 0);
    run("t4_mon", 8);
    SeatBelt = 1'b0;
    push_n(3, MONITOR, 0, 0); run("t4_glitch", 3);
    SeatBelt = 1'b1;
    push_n(9, MONITOR, 0, 0); run("t4_settle", 9);
    Ack = 1'b1; push(MONITOR, 0, 0); run("t4_ack_ign", 1); Ack = 1'b0;
    SeatBelt = 1'b0;
    push_n(6, MONITOR, 0, 0); push(CHIME, 0, 0); push_n(3, CHIME, 1, 1);
    run("t4_edge", 10);

    // 5: ignition off mid-episode -> OFF, outputs cleared a cycle later
    Ignition = 1'b0;
    for (int s = 1; s <= 6; s++) push(CHIME, ((s + 2) % 16) < 8, 1'b1);
    push(OFF, 0, 1); push_n(3, OFF, 0, 0);
    run("t5_ignoff", 10);

    // 6: async reset mid-beep, then full debounce latency again
    Ignition = 1'b1;
    push_n(6, OFF, 0, 0); push(MONITOR, 0, 0); push(CHIME, 0, 0); push_n(4, CHIME, 1, 1);
    run("t6_chime", 12);
    #3; nRst = 1'b0; #1;
    chk("t6_async_state", State, OFF);
    chk("t6_async_alarm", Alarm, 1'b0);
    chk("t6_async_lamp", WarnLamp, 1'b0);
    push_n(2, OFF, 0, 0); run("t6_inrst", 2);
    nRst = 1'b1;
    push_n(6, OFF, 0, 0); push(MONITOR, 0, 0); push(CHIME, 0, 0); push(CHIME, 1, 1);
    run("t6_reentry", 9);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
